// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the two-requester AXI4 read arbiter: FSM state
// encodings, grant constants, AXI field constants and grant-selection helpers.
package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic       GNT_IFU    = 1'b0;
    localparam logic       GNT_LSU    = 1'b1;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Fixed priority: the LSU wins whenever it asks.
    function automatic logic fixed_pick(input logic req0, input logic req1);
        logic pick;
        if (req1) begin
            pick = GNT_LSU;
        end else if (req0) begin
            pick = GNT_IFU;
        end else begin
            pick = GNT_IFU;
        end
        return pick;
    endfunction

    // Round robin: on contention the requester not granted last time wins.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        logic pick;
        if (req0 && req1) begin
            pick = ~last;
        end else if (req1) begin
            pick = GNT_LSU;
        end else begin
            pick = GNT_IFU;
        end
        return pick;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_arb_pick.sv
// arb_pick: combinational grant selection between the instruction cache (req0)
// and the LSU (req1). With ARB_RR_EN defined, a 1-bit last-grant pointer makes
// the choice round robin; otherwise the LSU has fixed priority.
module arb_pick
    import axi_rd_arbiter_pkg::*;
(
`ifdef ARB_RR_EN
    input  logic clk,
    input  logic rst,
    input  logic i_upd,
`endif
    input  logic i_req0,
    input  logic i_req1,
    output logic o_pick
);

`ifdef ARB_RR_EN
    logic r_last;

    // Remember which requester received the most recent grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= GNT_IFU;
        end else if (i_upd) begin
            r_last <= o_pick;
        end else begin
            r_last <= r_last;
        end
    end

    // Round-robin choice against the last-grant pointer.
    always_comb begin
        o_pick = rr_pick(i_req0, i_req1, r_last);
    end
`else
    // Fixed-priority choice, LSU first.
    always_comb begin
        o_pick = fixed_pick(i_req0, i_req1);
    end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one downstream AXI4 read channel between the
// instruction cache (m0) and the LSU (m1). Whole transactions are serialised:
// grant in IDLE, one AR handshake in ADDR, all R beats through rlast in DATA.
// Optional macro ARB_RR_EN selects round-robin instead of fixed LSU priority.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [ID_W-1:0]   m0_arid,
    input  logic [7:0]        m0_arlen,
    input  logic [2:0]        m0_arsize,
    input  logic [1:0]        m0_arburst,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,
    output logic [ID_W-1:0]   m0_rid,

    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [ID_W-1:0]   m1_arid,
    input  logic [7:0]        m1_arlen,
    input  logic [2:0]        m1_arsize,
    input  logic [1:0]        m1_arburst,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,
    output logic [ID_W-1:0]   m1_rid,

    output logic              out_arvalid,
    input  logic              out_arready,
    output logic [ADDR_W-1:0] out_araddr,
    output logic [ID_W-1:0]   out_arid,
    output logic [7:0]        out_arlen,
    output logic [2:0]        out_arsize,
    output logic [1:0]        out_arburst,
    input  logic              out_rvalid,
    output logic              out_rready,
    input  logic [DATA_W-1:0] out_rdata,
    input  logic [1:0]        out_rresp,
    input  logic              out_rlast,
    input  logic [ID_W-1:0]   out_rid
);

    state_t r_state;
    state_t w_next;
    logic   r_gnt;
    logic   w_pick;
    logic   w_any_req;
    logic   w_grant_upd;
    logic   w_g_arvalid;
    logic   w_g_rready;

    assign w_any_req   = m0_arvalid | m1_arvalid;
    assign w_grant_upd = (r_state == IDLE) & w_any_req;

    arb_pick u_arb_pick (
`ifdef ARB_RR_EN
        .clk    (clk),
        .rst    (rst),
        .i_upd  (w_grant_upd),
`endif
        .i_req0 (m0_arvalid),
        .i_req1 (m1_arvalid),
        .o_pick (w_pick)
    );

    // Granted requester's handshake inputs, used by the next-state logic.
    always_comb begin
        if (r_gnt == GNT_LSU) begin
            w_g_arvalid = m1_arvalid;
            w_g_rready  = m1_rready;
        end else begin
            w_g_arvalid = m0_arvalid;
            w_g_rready  = m0_rready;
        end
    end

    // State and grant registers; the grant is latched only when leaving IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= GNT_IFU;
        end else begin
            r_state <= w_next;
            if (w_grant_upd) begin
                r_gnt <= w_pick;
            end else begin
                r_gnt <= r_gnt;
            end
        end
    end

    // Next-state logic: grant, address handshake, then beats until rlast.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next = ADDR;
                end else begin
                    w_next = IDLE;
                end
            end
            ADDR: begin
                // A withdrawn request abandons the grant without issuing anything.
                if (!w_g_arvalid) begin
                    w_next = IDLE;
                end else if (out_arready) begin
                    w_next = DATA;
                end else begin
                    w_next = ADDR;
                end
            end
            DATA: begin
                if (out_rvalid && w_g_rready && out_rlast) begin
                    w_next = IDLE;
                end else begin
                    w_next = DATA;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Output muxing: AR from the granted requester in ADDR, R to it in DATA,
    // everything else driven to zero.
    always_comb begin
        m0_arready  = 1'b0;
        m1_arready  = 1'b0;
        m0_rvalid   = 1'b0;
        m0_rdata    = {DATA_W{1'b0}};
        m0_rresp    = RESP_OKAY;
        m0_rlast    = 1'b0;
        m0_rid      = {ID_W{1'b0}};
        m1_rvalid   = 1'b0;
        m1_rdata    = {DATA_W{1'b0}};
        m1_rresp    = RESP_OKAY;
        m1_rlast    = 1'b0;
        m1_rid      = {ID_W{1'b0}};
        out_arvalid = 1'b0;
        out_araddr  = {ADDR_W{1'b0}};
        out_arid    = {ID_W{1'b0}};
        out_arlen   = 8'd0;
        out_arsize  = 3'd0;
        out_arburst = 2'd0;
        out_rready  = 1'b0;
        case (r_state)
            IDLE: begin
                out_arvalid = 1'b0;
            end
            ADDR: begin
                if (r_gnt == GNT_LSU) begin
                    out_arvalid = m1_arvalid;
                    out_araddr  = m1_araddr;
                    out_arid    = m1_arid;
                    out_arlen   = m1_arlen;
                    out_arsize  = m1_arsize;
                    out_arburst = m1_arburst;
                    m1_arready  = out_arready;
                end else begin
                    out_arvalid = m0_arvalid;
                    out_araddr  = m0_araddr;
                    out_arid    = m0_arid;
                    out_arlen   = m0_arlen;
                    out_arsize  = m0_arsize;
                    out_arburst = m0_arburst;
                    m0_arready  = out_arready;
                end
            end
            DATA: begin
                if (r_gnt == GNT_LSU) begin
                    m1_rvalid  = out_rvalid;
                    m1_rdata   = out_rdata;
                    m1_rresp   = out_rresp;
                    m1_rlast   = out_rlast;
                    m1_rid     = out_rid;
                    out_rready = m1_rready;
                end else begin
                    m0_rvalid  = out_rvalid;
                    m0_rdata   = out_rdata;
                    m0_rresp   = out_rresp;
                    m0_rlast   = out_rlast;
                    m0_rid     = out_rid;
                    out_rready = m0_rready;
                end
            end
            default: begin
                out_rready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter. Inputs change 1 time unit
// after a rising edge; outputs are compared in the same cycle, away from the edge.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
    logic [31:0] m0_araddr, m0_rdata;
    logic [3:0]  m0_arid, m0_rid;
    logic [7:0]  m0_arlen;
    logic [2:0]  m0_arsize;
    logic [1:0]  m0_arburst, m0_rresp;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
    logic [31:0] m1_araddr, m1_rdata;
    logic [3:0]  m1_arid, m1_rid;
    logic [7:0]  m1_arlen;
    logic [2:0]  m1_arsize;
    logic [1:0]  m1_arburst, m1_rresp;
    logic        out_arvalid, out_arready, out_rvalid, out_rready, out_rlast;
    logic [31:0] out_araddr, out_rdata;
    logic [3:0]  out_arid, out_rid;
    logic [7:0]  out_arlen;
    logic [2:0]  out_arsize;
    logic [1:0]  out_arburst, out_rresp;

    int n_checks = 0;
    int n_fails  = 0;
    logic exp_g;

    axi_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
        .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
        .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rid(m0_rid),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
        .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
        .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rid(m1_rid),
        .out_arvalid(out_arvalid), .out_arready(out_arready), .out_araddr(out_araddr),
        .out_arid(out_arid), .out_arlen(out_arlen), .out_arsize(out_arsize),
        .out_arburst(out_arburst), .out_rvalid(out_rvalid), .out_rready(out_rready),
        .out_rdata(out_rdata), .out_rresp(out_rresp), .out_rlast(out_rlast), .out_rid(out_rid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // All handshake outputs low, as seen in IDLE.
    task automatic check_quiet(input string tag);
        check({tag, ".ready_valid"},
              {60'd0, m0_arready, m1_arready, out_arvalid, out_rready}, 64'd0);
        check({tag, ".rvalid"}, {62'd0, m0_rvalid, m1_rvalid}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        m0_arvalid = 1'b0; m0_araddr = 32'h0; m0_arid = 4'h1; m0_arlen = 8'd0;
        m0_arsize = 3'b010; m0_arburst = 2'b01; m0_rready = 1'b1;
        m1_arvalid = 1'b0; m1_araddr = 32'h0; m1_arid = 4'h3; m1_arlen = 8'd0;
        m1_arsize = 3'b010; m1_arburst = 2'b01; m1_rready = 1'b1;
        out_arready = 1'b1; out_rvalid = 1'b0; out_rdata = 32'h0;
        out_rresp = 2'b00; out_rlast = 1'b0; out_rid = 4'h0;
        repeat (3) tick();
        rst = 1'b0;

        // ---- reset state, downstream valid asserted to prove gating
        out_rvalid = 1'b1;
        #1;
        check_quiet("reset");
        check("reset.araddr", {32'd0, out_araddr}, 64'd0);
        out_rvalid = 1'b0;

        // ---- single m0 request, four beats
        m0_arvalid = 1'b1; m0_araddr = 32'h8000_0010; m0_arlen = 8'd3; m0_arid = 4'h2;
        #1;
        check("t1.idle_arvalid", {63'd0, out_arvalid}, 64'd0);
        check("t1.idle_arready", {63'd0, m0_arready}, 64'd0);
        tick();
        check("t1.arvalid", {63'd0, out_arvalid}, 64'd1);
        check("t1.araddr", {32'd0, out_araddr}, 64'h8000_0010);
        check("t1.arlen_id", {52'd0, out_arlen, out_arid}, {52'd0, 8'd3, 4'h2});
        check("t1.arready", {62'd0, m0_arready, m1_arready}, 64'd2);
        tick();
        m0_arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            out_rvalid = 1'b1; out_rdata = 32'hA000_0000 + 32'(i);
            out_rlast = (i == 3); out_rid = 4'h2;
            #1;
            check("t1.rvalid", {62'd0, m0_rvalid, m1_rvalid}, 64'd2);
            check("t1.rdata", {32'd0, m0_rdata}, {32'd0, 32'hA000_0000 + 32'(i)});
            check("t1.rlast_rid", {59'd0, m0_rlast, m0_rid}, {59'd0, (i == 3), 4'h2});
            check("t1.rready", {63'd0, out_rready}, 64'd1);
            tick();
        end
        // out_rvalid still high: IDLE must block it
        #1;
        check_quiet("t1.after_last");
        out_rvalid = 1'b0; out_rlast = 1'b0;

        // ---- simultaneous requests: m1 first (fixed priority, or RR pointer=m0)
        m0_arvalid = 1'b1; m0_araddr = 32'h8000_0000; m0_arlen = 8'd0; m0_arid = 4'h1;
        m1_arvalid = 1'b1; m1_araddr = 32'h8000_1000; m1_arlen = 8'd0; m1_arid = 4'h3;
        tick();
        check("t2.first_addr", {32'd0, out_araddr}, 64'h8000_1000);
        check("t2.first_ready", {62'd0, m0_arready, m1_arready}, 64'd1);
        tick();
        m1_arvalid = 1'b0;
        out_rvalid = 1'b1; out_rlast = 1'b1; out_rdata = 32'h1111_0001; out_rid = 4'h3;
        #1;
        check("t2.first_r", {62'd0, m0_rvalid, m1_rvalid}, 64'd1);
        check("t2.first_rid", {60'd0, m1_rid}, 64'd3);
        check("t2.m0_wait", {63'd0, m0_arready}, 64'd0);
        tick();
        out_rvalid = 1'b0;
        #1;
        check_quiet("t2.gap");
        tick();
        check("t2.second_addr", {32'd0, out_araddr}, 64'h8000_0000);
        check("t2.second_ready", {62'd0, m0_arready, m1_arready}, 64'd2);
        tick();
        m0_arvalid = 1'b0;
        out_rvalid = 1'b1; out_rlast = 1'b1; out_rdata = 32'h1111_0000; out_rid = 4'h1;
        #1;
        check("t2.second_r", {62'd0, m0_rvalid, m1_rvalid}, 64'd2);
        tick();
        out_rvalid = 1'b0; out_rlast = 1'b0;

        // ---- both held for four transactions; last grant was m0
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        for (int t = 0; t < 4; t++) begin
`ifdef ARB_RR_EN
            exp_g = (t % 2 == 0);
`else
            exp_g = 1'b1;
`endif
            tick();
            check("t3.grant_id", {60'd0, out_arid}, exp_g ? 64'd3 : 64'd1);
            tick();
            out_rvalid = 1'b1; out_rlast = 1'b1;
            #1;
            check("t3.rvalid", {62'd0, m0_rvalid, m1_rvalid}, exp_g ? 64'd1 : 64'd2);
            tick();
            out_rvalid = 1'b0; out_rlast = 1'b0;
        end
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        tick();

        // ---- m0 rready stalled for 3 cycles
        m0_arvalid = 1'b1; m0_arlen = 8'd1;
        tick();
        tick();
        m0_arvalid = 1'b0;
        out_rvalid = 1'b1; out_rdata = 32'hDEAD_BEEF; out_rlast = 1'b0; m0_rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4.stall_rready", {63'd0, out_rready}, 64'd0);
            check("t4.stall_data", {31'd0, m0_rvalid, m0_rdata}, {31'd0, 1'b1, 32'hDEAD_BEEF});
            tick();
        end
        m0_rready = 1'b1;
        #1;
        check("t4.release", {31'd0, out_rready, m0_rdata}, {31'd0, 1'b1, 32'hDEAD_BEEF});
        tick();
        out_rdata = 32'h1234_5678; out_rlast = 1'b1;
        #1;
        check("t4.beat2", {30'd0, m0_rvalid, m0_rlast, m0_rdata}, {30'd0, 2'b11, 32'h1234_5678});
        tick();
        out_rvalid = 1'b0; out_rlast = 1'b0;
        #1;
        check_quiet("t4.done");

        // ---- reset during beat 2 of 4
        m0_arvalid = 1'b1; m0_arlen = 8'd3;
        tick();
        tick();
        m0_arvalid = 1'b0;
        out_rvalid = 1'b1; out_rlast = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_quiet("t5.after_rst");
        out_rvalid = 1'b0;
        m1_arvalid = 1'b1; m1_araddr = 32'h8000_2000; m1_arlen = 8'd0; m1_arid = 4'h5;
        tick();
        check("t5.m1_addr", {32'd0, out_araddr}, 64'h8000_2000);
        check("t5.m1_ready", {62'd0, m0_arready, m1_arready}, 64'd1);
        tick();
        m1_arvalid = 1'b0;
        out_rvalid = 1'b1; out_rlast = 1'b1; out_rdata = 32'h5555_AAAA; out_rid = 4'h5;
        #1;
        check("t5.m1_data", {28'd0, m1_rid, m1_rdata}, {28'd0, 4'h5, 32'h5555_AAAA});
        tick();
        out_rvalid = 1'b0; out_rlast = 1'b0;

        // ---- withdrawn request in ADDR returns to IDLE without issuing
        m0_arvalid = 1'b1; m0_araddr = 32'h8000_0040; m0_arlen = 8'd0;
        tick();
        m0_arvalid = 1'b0;
        tick();
        m0_arvalid = 1'b1;
        #1;
        check("t6.back_idle", {62'd0, out_arvalid, m0_arready}, 64'd0);
        m0_arvalid = 1'b0;
        tick();

        // ---- out_arready low for 5 cycles, m1 arrives meanwhile
        out_arready = 1'b0;
        m0_arvalid = 1'b1; m0_araddr = 32'h8000_0080; m0_arlen = 8'd1;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) m1_arvalid = 1'b1;
            #1;
            check("t7.held", {31'd0, out_arvalid, out_araddr}, {31'd0, 1'b1, 32'h8000_0080});
            check("t7.ready_low", {62'd0, m0_arready, m1_arready}, 64'd0);
            tick();
        end
        out_arready = 1'b1;
        #1;
        check("t7.ready_rise", {62'd0, m0_arready, m1_arready}, 64'd2);
        tick();
        m0_arvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            out_rvalid = 1'b1; out_rlast = (i == 1);
            #1;
            check("t7.m1_blocked", {62'd0, m1_arready, m0_rvalid}, 64'd1);
            tick();
        end
        out_rvalid = 1'b0; out_rlast = 1'b0;
        tick();
        check("t7.m1_granted", {31'd0, m1_arready, out_araddr}, {31'd0, 1'b1, 32'h8000_2000});
        tick();
        m1_arvalid = 1'b0;
        out_rvalid = 1'b1; out_rlast = 1'b1;
        tick();
        out_rvalid = 1'b0; out_rlast = 1'b0;
        #1;
        check_quiet("t7.done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-requester arbiter that shares the single downstream AXI4 read channel between the instruction cache (m0) and the LSU (m1).
- Sits between the cache/LSU read masters and the core's external read port.
- Serialises whole transactions: one AR handshake, then all R beats up to and including rlast, before the next grant.
- Read-only; write channels are out of scope.

Parameters:
- ADDR_W, 32, address width of all AR channels
- DATA_W, 32, data width of all R channels
- ID_W, 4, AXI ID width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- m0_arvalid / m1_arvalid  in  1  requester AR valid
- m0_arready / m1_arready  out  1  requester AR ready
- m0_araddr / m1_araddr  in  ADDR_W  requester address
- m0_arid / m1_arid  in  ID_W  requester ID
- m0_arlen / m1_arlen  in  8  burst length minus 1
- m0_arsize / m1_arsize  in  3  beat size
- m0_arburst / m1_arburst  in  2  burst type
- m0_rvalid / m1_rvalid  out  1  requester R valid
- m0_rready / m1_rready  in  1  requester R ready
- m0_rdata / m1_rdata  out  DATA_W  read data
- m0_rresp / m1_rresp  out  2  response
- m0_rlast / m1_rlast  out  1  last beat
- m0_rid / m1_rid  out  ID_W  response ID
- out_arvalid, out_araddr, out_arid, out_arlen, out_arsize, out_arburst  out  AR fields to downstream
- out_arready  in  1  downstream AR ready
- out_rvalid, out_rdata, out_rresp, out_rlast, out_rid  in  R fields from downstream
- out_rready  out  1  R ready to downstream

Behaviour:
- States: IDLE, ADDR, DATA. Registered state and registered grant (gnt: 0 = m0, 1 = m1).
- Reset (rst=1 at a clock edge): state to IDLE, gnt to 0, RR pointer to 0.
  - All ready and valid outputs are 0 while in IDLE: m*_arready, m*_rvalid, out_arvalid, out_rready.
  - Data, ID and resp outputs are don't-care when the matching valid is 0, but drive 0 in IDLE.
- IDLE:
  - If any m*_arvalid is high, latch gnt per the arbitration rule and go to ADDR.
  - Otherwise stay in IDLE.
  - No arready is given in IDLE, so a grant costs one cycle.
- ADDR:
  - Granted requester's AR fields drive out_ar* combinationally.
  - out_arvalid = mG_arvalid; mG_arready = out_arready.
  - Non-granted arready = 0.
  - On out_arvalid & out_arready, go to DATA.
  - If the granted arvalid deasserts before the handshake (an AXI violation), return to IDLE. No transaction is issued.
- DATA:
  - Downstream R fields are routed to the granted requester: mG_rvalid = out_rvalid, out_rready = mG_rready.
  - Non-granted rvalid = 0.
  - Beats with rlast=0 stay in DATA.
  - On out_rvalid & out_rready & out_rlast, go to IDLE.
- Back-to-back: minimum one IDLE cycle between transactions. Full turnaround is AR at earliest 1 cycle after arvalid rises.
- Default arbitration (fixed priority): when both request, m1 (LSU) wins.
- A request arriving while the other master's transaction is in progress waits. Its arvalid is held, arready stays 0.
- Reset mid-burst aborts the transfer. The downstream slave must be reset in the same cycle.
- rid is passed through unchanged; no ID remapping.

Optional Feature:
- ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit pointer records the last granted requester and updates on every grant.
  - On a simultaneous request, the requester not granted last wins.
  - A single requester is always granted.
- ARB_RR_EN undefined: fixed priority m1 > m0. No pointer register.

Decomposition:
- Shared package holds:
  - state encodings (IDLE=2'd0, ADDR=2'd1, DATA=2'd2)
  - grant constants (GNT_IFU=0, GNT_LSU=1)
  - AXI constants (BURST_INCR=2'b01, SIZE_WORD=3'b010, RESP_OKAY=2'b00)
- One sub-module, arb_pick: combinational grant selection from two requests plus the RR pointer, with the pointer register under ARB_RR_EN.
- AR/R muxing stays in the top module.

Test Plan:
- Single m0 request, addr 0x8000_0010, arlen 3, out_arready=1 → out_arvalid high in cycle 1, four R beats routed to m0 only; m1_rvalid stays 0; state reaches IDLE after the rlast handshake.
- Both request in the same cycle (m0 0x8000_0000, m1 0x8000_1000), default build → m1 issues first, m0 issues after m1's rlast. With ARB_RR_EN and pointer=1 → m0 first.
- ARB_RR_EN, both held continuously for 4 transactions → grant order alternates 1,0,1,0 (or 0,1,0,1) and neither requester starves.
- m0_rready held 0 for 3 cycles during a beat → out_rready=0; data 0xDEADBEEF is held and delivered once rready rises; no beat is lost or duplicated.
- rst asserted during beat 2 of 4 → next cycle all valid/ready outputs are 0 and state is IDLE; a fresh m1 request afterwards completes normally.
- out_arready held 0 for 5 cycles in ADDR → out_arvalid is held; m1 request arriving meanwhile gets arready=0 until m0's burst ends.
